// File: rtl/axi_ar_beat_gen.sv
// AXI read-address beat generator.
// Takes one AR burst at a time and expands it into per-beat AHB commands:
// beat address, id and last flag go to the command FIFO, transfer size to
// the size FIFO. Both FIFOs are always pushed together in the same cycle.

module axi_ar_beat_gen #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              cmd_full,
  output logic              cmd_wr_en,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [ID_W-1:0]   cmd_id,
  output logic              cmd_last,
  input  logic              size_full,
  output logic              size_wr_en,
  output logic [2:0]        size_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Effective burst kind after folding reserved and illegal-length WRAP into INCR.
  localparam logic [1:0] KIND_FIXED = 2'd0;
  localparam logic [1:0] KIND_INCR  = 2'd1;
  localparam logic [1:0] KIND_WRAP  = 2'd2;

  state_t            state_reg, state_next;
  logic              arready_reg, arready_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        size_reg, size_next;
  logic [1:0]        kind_reg, kind_next;

  logic              push;
  logic              last_beat;
  logic              wrap_len_ok;
  logic [1:0]        ar_kind;
  logic [ADDR_W-1:0] beat_bytes;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] wrap_addr;
  logic [ADDR_W-1:0] adv_addr;

  // A beat is emitted only when both FIFOs can accept it, so they never diverge.
  assign push      = (state_reg == BURST) && !cmd_full && !size_full;
  assign last_beat = (cnt_reg == len_reg);

  // Decode the incoming AR burst type into the kind actually executed.
  always_comb begin
    wrap_len_ok = (arlen == LEN_W'(1)) || (arlen == LEN_W'(3)) ||
                  (arlen == LEN_W'(7)) || (arlen == LEN_W'(15));
    ar_kind     = KIND_INCR;
    if (arburst == 2'b00) begin
      ar_kind = KIND_FIXED;
    end else if ((arburst == 2'b10) && wrap_len_ok) begin
      ar_kind = KIND_WRAP;
    end
  end

  // Address of the beat following the current one, for each burst kind.
  always_comb begin
    beat_bytes = ADDR_W'(1) << size_reg;
    // INCR aligns after the first beat; the sum wraps modulo 2^ADDR_W.
    incr_addr  = (addr_reg & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
    // WRAP keeps the upper bits and lets only the bits inside the window roll.
    wrap_mask  = ((ADDR_W'(len_reg) + ADDR_W'(1)) << size_reg) - ADDR_W'(1);
    wrap_addr  = (addr_reg & ~wrap_mask) | ((addr_reg + beat_bytes) & wrap_mask);
    case (kind_reg)
      KIND_FIXED: adv_addr = addr_reg;
      KIND_WRAP:  adv_addr = wrap_addr;
      default:    adv_addr = incr_addr;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      arready_reg <= 1'b0;
      addr_reg    <= '0;
      id_reg      <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      size_reg    <= '0;
      kind_reg    <= KIND_FIXED;
    end else begin
      state_reg   <= state_next;
      arready_reg <= arready_next;
      addr_reg    <= addr_next;
      id_reg      <= id_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      size_reg    <= size_next;
      kind_reg    <= kind_next;
    end
  end

  // Next-state logic: accept one AR burst in IDLE, walk its beats in BURST.
  always_comb begin
    state_next   = state_reg;
    arready_next = arready_reg;
    addr_next    = addr_reg;
    id_next      = id_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    size_next    = size_reg;
    kind_next    = kind_reg;
    case (state_reg)
      IDLE: begin
        arready_next = 1'b1;
        if (arvalid && arready_reg) begin
          addr_next    = araddr;
          id_next      = arid;
          len_next     = arlen;
          size_next    = arsize;
          kind_next    = ar_kind;
          cnt_next     = '0;
          state_next   = BURST;
          arready_next = 1'b0;
        end
      end
      BURST: begin
        arready_next = 1'b0;
        if (push) begin
          cnt_next  = cnt_reg + LEN_W'(1);
          addr_next = adv_addr;
          if (last_beat) begin
            state_next   = IDLE;
            arready_next = 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        arready_next = 1'b0;
      end
    endcase
  end

  assign arready    = arready_reg;
  assign cmd_wr_en  = push;
  assign size_wr_en = push;
  assign cmd_addr   = addr_reg;
  assign cmd_id     = id_reg;
  assign cmd_last   = (state_reg == BURST) && last_beat;
  assign size_data  = size_reg;

endmodule

// File: tb/tb_axi_ar_beat_gen.sv
// Testbench for axi_ar_beat_gen: table of directed bursts with expected
// addresses, hand-written multi-cycle sequences (stall, back-to-back,
// reset mid-burst), and randomized bursts checked against an arithmetic model.

module tb_axi_ar_beat_gen;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  logic              wclk = 1'b0;
  logic              resetn;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              cmd_full;
  logic              cmd_wr_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ID_W-1:0]   cmd_id;
  logic              cmd_last;
  logic              size_full;
  logic              size_wr_en;
  logic [2:0]        size_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]       burst;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [3:0]       id;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs[8];

  axi_ar_beat_gen #(
    .ADDR_W(ADDR_W),
    .ID_W  (ID_W),
    .LEN_W (LEN_W)
  ) dut (
    .wclk      (wclk),
    .resetn    (resetn),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .cmd_full  (cmd_full),
    .cmd_wr_en (cmd_wr_en),
    .cmd_addr  (cmd_addr),
    .cmd_id    (cmd_id),
    .cmd_last  (cmd_last),
    .size_full (size_full),
    .size_wr_en(size_wr_en),
    .size_data (size_data)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: address of beat i computed directly from the burst rules.
  function automatic void model(input logic [1:0] b, input logic [31:0] a,
                                input logic [7:0] l, input logic [2:0] s);
    logic [31:0] bytes, ws, base, off;
    bit wrap;
    bytes = 32'd1 << s;
    wrap  = (b == 2'b10) && (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15);
    exp_q.delete();
    for (int i = 0; i <= int'(l); i++) begin
      if (b == 2'b00) begin
        exp_q.push_back(a);
      end else if (wrap) begin
        ws   = (32'(l) + 32'd1) * bytes;
        base = a - (a % ws);
        off  = ((a - base) + 32'(i) * bytes) % ws;
        exp_q.push_back(base + off);
      end else if (i == 0) begin
        exp_q.push_back(a);
      end else begin
        exp_q.push_back((a - (a % bytes)) + 32'(i) * bytes);
      end
    end
  endfunction

  // Issue one AR burst and check every cycle until its final beat is pushed.
  task automatic do_burst(input logic [1:0] b, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [3:0] id,
                          input int stall_beat, input int stall_len, input bit rand_bp);
    int  n, beats, cyc, stalled;
    bit  full_c, full_s, exp_push;
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(negedge wclk);
      n++;
    end
    check("ar_wait", arready, 1);
    @(negedge wclk);
    // Scramble the AR bus so any failure to latch shows up.
    arvalid = 1'b0; arid = ~id; araddr = $urandom; arlen = 8'($urandom);
    arsize = 3'($urandom); arburst = 2'($urandom);
    beats = 0; cyc = 0; stalled = 0;
    while (beats < int'(l) + 1 && cyc < 10 * (int'(l) + 1) + 50) begin
      full_c = 1'b0;
      full_s = 1'b0;
      if (rand_bp && cyc < 3 * (int'(l) + 1)) begin
        full_c = ($urandom % 5 == 0);
        full_s = ($urandom % 5 == 0);
      end else if (beats == stall_beat && stalled < stall_len) begin
        full_s = 1'b1;
        stalled++;
      end
      cmd_full = full_c; size_full = full_s;
      #1;
      exp_push = !(full_c || full_s);
      check("arready_busy", arready, 0);
      check("cmd_wr_en", cmd_wr_en, exp_push);
      check("size_wr_en", size_wr_en, exp_push);
      check("cmd_addr", cmd_addr, exp_q[beats]);
      check("cmd_last", cmd_last, beats == int'(l));
      check("cmd_id", cmd_id, id);
      check("size_data", size_data, s);
      if (exp_push) beats++;
      cyc++;
      @(negedge wclk);
    end
    cmd_full = 1'b0; size_full = 1'b0;
    #1;
    check("arready_after", arready, 1);
    check("no_extra_push", cmd_wr_en, 0);
    $display("[TB] burst=%0d addr=0x%08h len=%0d size=%0d id=%0d beats=%0d cycles=%0d",
             b, a, l, s, id, beats, cyc);
  endtask

  initial begin
    int pushes;
    logic [1:0]  rb;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [3:0]  rid;

    vecs[0] = '{2'b01, 32'h0000_1002, 8'd3, 3'd2, 4'd1,
                {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1002}};
    vecs[1] = '{2'b10, 32'h0000_1018, 8'd3, 3'd2, 4'd2,
                {32'h0000_1014, 32'h0000_1010, 32'h0000_101C, 32'h0000_1018}};
    vecs[2] = '{2'b00, 32'h0000_2000, 8'd2, 3'd1, 4'd5,
                {32'h0, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000}};
    vecs[3] = '{2'b10, 32'h0000_1018, 8'd2, 3'd2, 4'd3,
                {32'h0, 32'h0000_1020, 32'h0000_101C, 32'h0000_1018}};
    vecs[4] = '{2'b11, 32'h0000_0FFE, 8'd1, 3'd1, 4'd9,
                {32'h0, 32'h0, 32'h0000_1000, 32'h0000_0FFE}};
    vecs[5] = '{2'b01, 32'hFFFF_FFFC, 8'd1, 3'd2, 4'd6,
                {32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC}};
    vecs[6] = '{2'b10, 32'h0000_0108, 8'd1, 3'd3, 4'd12,
                {32'h0, 32'h0, 32'h0000_0100, 32'h0000_0108}};
    vecs[7] = '{2'b01, 32'h0000_0055, 8'd0, 3'd0, 4'd15,
                {32'h0, 32'h0, 32'h0, 32'h0000_0055}};

    resetn = 1'b0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arsize = '0; arburst = '0; cmd_full = 1'b0; size_full = 1'b0;
    #1;
    check("rst_arready", arready, 0);
    check("rst_cmd_wr_en", cmd_wr_en, 0);
    check("rst_size_wr_en", size_wr_en, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_cmd_last", cmd_last, 0);
    check("rst_size_data", size_data, 0);
    repeat (2) @(negedge wclk);
    resetn = 1'b1;
    @(negedge wclk);
    #1;
    check("arready_rise", arready, 1);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      exp_q.delete();
      for (int i = 0; i <= int'(vecs[v].len); i++) exp_q.push_back(vecs[v].exp[i]);
      do_burst(vecs[v].burst, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].id, -1, 0, 1'b0);
    end

    // INCR len 7 with size FIFO full for 3 cycles at beat 2.
    model(2'b01, 32'h0000_3000, 8'd7, 3'd2);
    do_burst(2'b01, 32'h0000_3000, 8'd7, 3'd2, 4'd4, 2, 3, 1'b0);

    // Back-to-back single-beat bursts with arvalid held high.
    arburst = 2'b01; araddr = 32'h0000_4000; arlen = 8'd0; arsize = 3'd2; arid = 4'd7;
    arvalid = 1'b1;
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      check("b2b_arready", arready, (i % 2 == 0));
      check("b2b_wr_en", cmd_wr_en, (i % 2 == 1));
      check("b2b_last", cmd_last, (i % 2 == 1));
      if (cmd_wr_en) begin
        pushes++;
        check("b2b_addr", cmd_addr, 32'h0000_4000);
      end
      if (i == 5) arvalid = 1'b0;
      @(negedge wclk);
      #1;
    end
    check("b2b_pushes", pushes, 3);
    check("b2b_idle_arready", arready, 1);
    check("b2b_idle_wr_en", cmd_wr_en, 0);
    @(negedge wclk);
    #1;
    check("b2b_no_rehandshake", arready, 1);
    $display("[TB] back-to-back single-beat bursts pushes=%0d", pushes);

    // Reset asserted during beat 3 of an arlen=15 INCR burst.
    arburst = 2'b01; araddr = 32'h0000_5000; arlen = 8'd15; arsize = 3'd2; arid = 4'd10;
    arvalid = 1'b1;
    for (int n = 0; n < 20 && arready !== 1'b1; n++) @(negedge wclk);
    check("rst_mid_ar_wait", arready, 1);
    @(negedge wclk);
    arvalid = 1'b0;
    repeat (3) @(negedge wclk);
    #1;
    check("rst_mid_beat3_addr", cmd_addr, 32'h0000_500C);
    check("rst_mid_beat3_push", cmd_wr_en, 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_arready", arready, 0);
    check("rst_mid_cmd_wr_en", cmd_wr_en, 0);
    check("rst_mid_size_wr_en", size_wr_en, 0);
    check("rst_mid_cmd_addr", cmd_addr, 0);
    check("rst_mid_cmd_id", cmd_id, 0);
    check("rst_mid_cmd_last", cmd_last, 0);
    check("rst_mid_size_data", size_data, 0);
    @(negedge wclk);
    resetn = 1'b1;
    @(negedge wclk);
    #1;
    check("rst_mid_release_arready", arready, 1);
    check("rst_mid_release_wr_en", cmd_wr_en, 0);
    $display("[TB] reset mid-burst at beat 3 done");
    model(2'b01, 32'h0000_6004, 8'd5, 3'd2);
    do_burst(2'b01, 32'h0000_6004, 8'd5, 3'd2, 4'd11, -1, 0, 1'b0);

    // Randomized bursts with random backpressure against the model.
    for (int k = 0; k < 40; k++) begin
      rb  = 2'($urandom);
      ra  = $urandom;
      rl  = (k % 8 == 0) ? 8'($urandom % 64) : 8'($urandom % 16);
      rs  = 3'($urandom);
      rid = 4'($urandom);
      model(rb, ra, rl, rs);
      do_burst(rb, ra, rl, rs, rid, -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
